// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and pointer-coding helpers for the FIFO read-side controller.
package fifo_rd_ctrl_pkg;

   // Read-side controller states (2-bit encoding).
   typedef enum logic [1:0] {
      RESET_ST = 2'd0,
      IDLE     = 2'd1,
      READ     = 2'd2,
      FLUSH    = 2'd3
   } rd_state_e;

   // Binary to Gray conversion; callers cast to/from their pointer width.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary conversion: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Consumer-side bus of the FIFO read controller, plus the Gray pointer exchange
// with the write domain.
interface fifo_rd_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic              remove;
   logic              flush;
   logic [ADDR_W:0]   wr_ptr_gray;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [ADDR_W:0]   rd_ptr_gray;
   logic              empty;
   logic              almost_empty;
   logic [ADDR_W:0]   rd_level;
   logic              underflow;
   logic              rd_busy;

   // Consumer / environment side.
   modport master (
      output remove, flush, wr_ptr_gray,
      input  rd_en, rd_addr, rd_valid, rd_ptr_gray, empty, almost_empty,
             rd_level, underflow, rd_busy
   );

   // Controller side.
   modport slave (
      input  remove, flush, wr_ptr_gray,
      output rd_en, rd_addr, rd_valid, rd_ptr_gray, empty, almost_empty,
             rd_level, underflow, rd_busy
   );
endinterface

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// Multi-flop synchroniser carrying the write domain's Gray pointer into clk_out.
// Gray coding guarantees at most one bit changes per write step, so each
// synchronised sample is either the old or the new pointer value.
module fifo_rd_ctrl_ptr_sync #(
   parameter int W      = 4,
   parameter int STAGES = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_sync [STAGES];

   // Shift the asynchronous input through STAGES flops; cleared by async reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_sync[i] <= {W{1'b0}};
         end
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO. Owns the read pointer (binary and
// Gray), synchronises the writer's Gray pointer, and derives empty, almost_empty,
// fill level and a sticky underflow flag. Flush drops all visible entries by
// moving the read pointer onto the synchronised write pointer.
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 2
) (
   input  logic           clk_out,
   input  logic           reset,
   fifo_rd_ctrl_if.slave  bus
);
   localparam int PW = ADDR_W + 1;

   rd_state_e         r_state;
   logic [PW-1:0]     r_rd_bin;
   logic [PW-1:0]     r_rd_gray;
   logic              r_rd_valid;
   logic              r_underflow;

   logic [PW-1:0]     w_wq_gray;
   logic [PW-1:0]     w_wq_bin;
   logic [PW-1:0]     w_rd_level;
   logic [PW-1:0]     w_rd_bin_nxt;
   logic              w_rd_window;
   logic              w_empty;
   logic              w_rd_en;

   fifo_rd_ctrl_ptr_sync #(
      .W      (PW),
      .STAGES (SYNC_STAGES)
   ) u_wr_sync (
      .i_clk   (clk_out),
      .i_rst_n (reset),
      .i_d     (bus.wr_ptr_gray),
      .o_q     (w_wq_gray)
   );

   // Level is computed from registered pointers only, so a moving writer can
   // only make it lag (understate), never overstate the readable entries.
   assign w_wq_bin     = PW'(gray2bin(32'(w_wq_gray)));
   assign w_rd_level   = w_wq_bin - r_rd_bin;
   assign w_rd_window  = (r_state == IDLE) || (r_state == READ);
   assign w_empty      = (w_rd_level == {PW{1'b0}}) || !w_rd_window;
   assign w_rd_en      = bus.remove & ~bus.flush & ~w_empty;
   assign w_rd_bin_nxt = r_rd_bin + PW'(1);

   assign bus.rd_en        = w_rd_en;
   assign bus.rd_addr      = r_rd_bin[ADDR_W-1:0];
   assign bus.rd_valid     = r_rd_valid;
   assign bus.rd_ptr_gray  = r_rd_gray;
   assign bus.empty        = w_empty;
   assign bus.almost_empty = (w_rd_level <= PW'(AE_THRESH));
   assign bus.rd_level     = w_rd_level;
   assign bus.underflow    = r_underflow;
   assign bus.rd_busy      = (r_state == READ);

   // FSM plus read pointer, read-valid and underflow registers; flush overrides everything.
   always_ff @(posedge clk_out or negedge reset) begin
      if (!reset) begin
         r_state     <= RESET_ST;
         r_rd_bin    <= {PW{1'b0}};
         r_rd_gray   <= {PW{1'b0}};
         r_rd_valid  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.flush) begin
         r_state     <= FLUSH;
         r_rd_bin    <= w_wq_bin;
         r_rd_gray   <= w_wq_gray;
         r_rd_valid  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         case (r_state)
            RESET_ST: r_state <= IDLE;
            IDLE,
            READ:     r_state <= w_rd_en ? READ : IDLE;
            FLUSH:    r_state <= IDLE;
            default:  r_state <= RESET_ST;
         endcase
         r_rd_valid <= w_rd_en;
         if (w_rd_en) begin
            r_rd_bin  <= w_rd_bin_nxt;
            r_rd_gray <= PW'(bin2gray(32'(w_rd_bin_nxt)));
         end
         if (bus.remove && w_empty && w_rd_window) begin
            r_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_W=3, SYNC_STAGES=2, AE_THRESH=2).
// The reference model counts entries with plain integers: an absolute write
// count, an absolute read count and a two-deep delay queue for visibility.
module tb_fifo_rd_ctrl;

   typedef struct {
      logic rm;
      logic fl;
      logic en;
      int   addr;
      logic emp;
      logic ae;
      int   lvl;
      logic vld;
      logic busy;
      logic uf;
      int   gray;
   } vec_t;

   logic clk_out = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state
   int   m_wr;
   int   m_rd;
   int   wq_q[$];
   bit   m_block;
   bit   m_busy;
   bit   m_valid;
   bit   m_uf;

   vec_t tbl[9];
   vec_t dummy_row;

   fifo_rd_ctrl_if #(.ADDR_W(3)) bus ();

   fifo_rd_ctrl #(
      .ADDR_W      (3),
      .SYNC_STAGES (2),
      .AE_THRESH   (2)
   ) u_dut (
      .clk_out (clk_out),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_out = ~clk_out;

   function automatic logic [3:0] b2g(input int b);
      logic [3:0] x;
      x = b[3:0];
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_wr    = 0;
      m_rd    = 0;
      wq_q    = {0, 0};
      m_block = 1'b1;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_uf    = 1'b0;
   endtask

   // One clock cycle: drive at negedge, compare against the model, advance at posedge.
   task automatic cycle(input logic rm, input logic fl, input bit use_row, input vec_t row);
      int vis;
      int lvl;
      bit emp;
      bit en;
      @(negedge clk_out);
      bus.remove      = rm;
      bus.flush       = fl;
      bus.wr_ptr_gray = b2g(m_wr);
      #1;
      vis = wq_q[0];
      lvl = vis - m_rd;
      emp = (lvl == 0) || m_block;
      en  = rm && !fl && !emp;
      chk("rd_en",        bus.rd_en,        en);
      chk("rd_addr",      bus.rd_addr,      m_rd & 7);
      chk("rd_valid",     bus.rd_valid,     m_valid);
      chk("rd_ptr_gray",  bus.rd_ptr_gray,  b2g(m_rd));
      chk("empty",        bus.empty,        emp);
      chk("almost_empty", bus.almost_empty, (lvl <= 2));
      chk("rd_level",     bus.rd_level,     lvl & 15);
      chk("underflow",    bus.underflow,    m_uf);
      chk("rd_busy",      bus.rd_busy,      m_busy);
      if (use_row) begin
         chk("tbl_rd_en",        bus.rd_en,        row.en);
         chk("tbl_rd_addr",      bus.rd_addr,      row.addr);
         chk("tbl_empty",        bus.empty,        row.emp);
         chk("tbl_almost_empty", bus.almost_empty, row.ae);
         chk("tbl_rd_level",     bus.rd_level,     row.lvl);
         chk("tbl_rd_valid",     bus.rd_valid,     row.vld);
         chk("tbl_rd_busy",      bus.rd_busy,      row.busy);
         chk("tbl_underflow",    bus.underflow,    row.uf);
         chk("tbl_rd_ptr_gray",  bus.rd_ptr_gray,  row.gray);
      end
      @(posedge clk_out);
      if (fl) begin
         m_rd    = vis;
         m_block = 1'b1;
         m_valid = 1'b0;
         m_busy  = 1'b0;
         m_uf    = 1'b0;
      end else begin
         if (rm && emp && !m_block) m_uf = 1'b1;
         m_valid = en;
         m_busy  = en;
         m_block = 1'b0;
         if (en) m_rd++;
      end
      void'(wq_q.pop_front());
      wq_q.push_back(m_wr);
   endtask

   task automatic step(input logic rm, input logic fl);
      cycle(rm, fl, 1'b0, dummy_row);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_rd_en"},        bus.rd_en,        1'b0);
      chk({pfx, "_rd_addr"},      bus.rd_addr,      3'd0);
      chk({pfx, "_rd_valid"},     bus.rd_valid,     1'b0);
      chk({pfx, "_rd_ptr_gray"},  bus.rd_ptr_gray,  4'd0);
      chk({pfx, "_empty"},        bus.empty,        1'b1);
      chk({pfx, "_almost_empty"}, bus.almost_empty, 1'b1);
      chk({pfx, "_rd_level"},     bus.rd_level,     4'd0);
      chk({pfx, "_underflow"},    bus.underflow,    1'b0);
      chk({pfx, "_rd_busy"},      bus.rd_busy,      1'b0);
   endtask

   initial begin
      // Table for the 5-entry drain: rm fl en addr emp ae lvl vld busy uf gray
      tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 3};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 2};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 6};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 7};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 7};
      dummy_row = tbl[0];

      // Reset with writer pointer at zero
      reset           = 1'b0;
      bus.remove      = 1'b0;
      bus.flush       = 1'b0;
      bus.wr_ptr_gray = 4'd0;
      model_reset();
      repeat (2) @(posedge clk_out);
      #1;
      chk_reset_values("rst");
      reset = 1'b1;

      // Writer at 5 entries, then drain with remove held for 6 cycles
      m_wr = 5;
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].rm, tbl[i].fl, 1'b1, tbl[i]);
      end

      // Pointer wrap: bring read pointer to 15 and writer to 17 (bin 1)
      m_wr = 13;
      idle(2);
      step(1'b0, 1'b1);
      idle(1);
      m_wr = 15;
      idle(2);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      m_wr = 17;
      idle(2);
      #1;
      chk("wrap_addr_pre", bus.rd_addr,     3'd7);
      chk("wrap_gray_pre", bus.rd_ptr_gray, 4'b1000);
      chk("wrap_lvl_pre",  bus.rd_level,    4'd2);
      step(1'b1, 1'b0);
      #1;
      chk("wrap_addr_1", bus.rd_addr,     3'd0);
      chk("wrap_gray_1", bus.rd_ptr_gray, 4'b0000);
      step(1'b1, 1'b0);
      #1;
      chk("wrap_addr_2", bus.rd_addr,     3'd1);
      chk("wrap_gray_2", bus.rd_ptr_gray, 4'b0001);
      chk("wrap_empty",  bus.empty,       1'b1);

      // Underflow persistence and clear by flush
      step(1'b1, 1'b0);
      #1;
      chk("uf_set", bus.underflow, 1'b1);
      idle(20);
      #1;
      chk("uf_hold", bus.underflow, 1'b1);
      step(1'b0, 1'b1);
      #1;
      chk("uf_clear", bus.underflow, 1'b0);
      idle(1);

      // Flush in the middle of a read burst
      m_wr = 22;
      idle(2);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      #1;
      chk("fl_empty", bus.empty,    1'b1);
      chk("fl_valid", bus.rd_valid, 1'b0);
      chk("fl_busy",  bus.rd_busy,  1'b0);
      chk("fl_level", bus.rd_level, 4'd0);
      chk("fl_addr",  bus.rd_addr,  3'd6);
      idle(1);
      #1;
      chk("fl_idle_level", bus.rd_level, 4'd0);
      chk("fl_idle_busy",  bus.rd_busy,  1'b0);

      // Async reset between edges while reading
      m_wr = 27;
      idle(2);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      @(negedge clk_out);
      bus.remove = 1'b1;
      #1;
      chk("pre_arst_busy", bus.rd_busy, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk_reset_values("arst");
      model_reset();
      bus.remove      = 1'b0;
      bus.wr_ptr_gray = 4'd0;
      @(posedge clk_out);
      #1 reset = 1'b1;

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ((m_wr - m_rd) < 8 && $urandom_range(0, 2) != 0) m_wr++;
         step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
